// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RISC-V core: FSM states, opcodes and select encodings.
// The TRAP state only exists when MAIN_FSM_TRAP_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
`ifdef MAIN_FSM_TRAP_EN
        , S_TRAP   = 4'd11
`endif
    } stateT;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_JAL,
        CLS_BEQ,
        CLS_ILLEGAL
    } instrClassT;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // aluOp codes understood by alu_deco
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode-to-instruction-class decoder shared by the DECODE and MEMADR steps.
module op_classify
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output instrClassT instrClass
);

    always_comb begin
        case (op)
            OP_LW:   instrClass = CLS_LOAD;
            OP_SW:   instrClass = CLS_STORE;
            OP_R:    instrClass = CLS_RTYPE;
            OP_I:    instrClass = CLS_ITYPE;
            OP_JAL:  instrClass = CLS_JAL;
            OP_BEQ:  instrClass = CLS_BEQ;
            default: instrClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute and drives datapath enables and selects.
// Optional MAIN_FSM_TRAP_EN adds a sticky TRAP state for unsupported opcodes.
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       memReady,
    output logic [1:0] aluOp,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       memReq,
    output logic       illegal
);

    stateT      state, nextState;
    instrClassT instrClass;
    logic       irWriteRaw, pcWriteRaw, regWriteRaw, memWriteRaw, memReqRaw;

    op_classify uClassify (
        .op         (op),
        .instrClass (instrClass)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= nextState;
    end

    always_comb begin
        // NOTE: every output is defaulted first so no branch of the case can infer a latch.
        nextState   = state;
        aluOp       = ALU_OP_ADD;
        aluSrcA     = SRCA_PC;
        aluSrcB     = SRCB_RS2;
        resultSrc   = RES_ALUOUT;
        adrSrc      = 1'b0;
        irWriteRaw  = 1'b0;
        pcWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        memReqRaw   = 1'b0;
        case (state)
            S_FETCH: begin
                memReqRaw  = 1'b1;
                aluSrcB    = SRCB_FOUR;
                resultSrc  = RES_ALU;
                irWriteRaw = memReady;
                pcWriteRaw = memReady;
                if (memReady) nextState = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (instrClass)
                    CLS_LOAD, CLS_STORE: nextState = S_MEMADR;
                    CLS_RTYPE:           nextState = S_EXECR;
                    CLS_ITYPE:           nextState = S_EXECI;
                    CLS_JAL:             nextState = S_JAL;
                    CLS_BEQ:             nextState = S_BEQ;
`ifdef MAIN_FSM_TRAP_EN
                    default:             nextState = S_TRAP;
`else
                    default:             nextState = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                aluSrcA   = SRCA_RS1;
                aluSrcB   = SRCB_IMM;
                nextState = (instrClass == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                memReqRaw = 1'b1;
                adrSrc    = 1'b1;
                if (memReady) nextState = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc   = RES_RDATA;
                regWriteRaw = 1'b1;
                nextState   = S_FETCH;
            end
            S_MEMWRITE: begin
                memReqRaw   = 1'b1;
                adrSrc      = 1'b1;
                memWriteRaw = memReady;
                if (memReady) nextState = S_FETCH;
            end
            S_EXECR: begin
                aluSrcA   = SRCA_RS1;
                aluOp     = ALU_OP_FUNCT;
                nextState = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA   = SRCA_RS1;
                aluSrcB   = SRCB_IMM;
                aluOp     = ALU_OP_FUNCT;
                nextState = S_ALUWB;
            end
            S_JAL: begin
                aluSrcA    = SRCA_OLDPC;
                aluSrcB    = SRCB_FOUR;
                pcWriteRaw = 1'b1;
                nextState  = S_ALUWB;
            end
            S_ALUWB: begin
                regWriteRaw = 1'b1;
                nextState   = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA    = SRCA_RS1;
                aluOp      = ALU_OP_SUB;
                pcWriteRaw = zero;
                nextState  = S_FETCH;
            end
`ifdef MAIN_FSM_TRAP_EN
            S_TRAP: nextState = S_TRAP;
`endif
            default: nextState = S_FETCH;
        endcase
    end

    // NOTE: strobes are gated by rst_n so nothing fires in the same cycle reset is asserted.
    assign irWrite  = irWriteRaw  & rst_n;
    assign pcWrite  = pcWriteRaw  & rst_n;
    assign regWrite = regWriteRaw & rst_n;
    assign memWrite = memWriteRaw & rst_n;
    assign memReq   = memReqRaw   & rst_n;

`ifdef MAIN_FSM_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    illegal <= 1'b0;
        else if (nextState == S_TRAP)  illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm; expected output vectors are hand-derived per step.
// Honours MAIN_FSM_TRAP_EN for the unsupported-opcode sequence.
module tb_main_fsm;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_BEQ = 7'b1100011;
    localparam logic [6:0] C_BAD = 7'b1111111;

    // {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, pcWrite, regWrite, memWrite, memReq, illegal}
    localparam logic [14:0] E_RST    = 15'b00_00_10_10_0_0_0_0_0_0_0;
    localparam logic [14:0] E_F_RDY  = 15'b00_00_10_10_0_1_1_0_0_1_0;
    localparam logic [14:0] E_F_WAIT = 15'b00_00_10_10_0_0_0_0_0_1_0;
    localparam logic [14:0] E_DEC    = 15'b00_01_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] E_MADR   = 15'b00_10_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] E_MRD    = 15'b00_00_00_00_1_0_0_0_0_1_0;
    localparam logic [14:0] E_MWB    = 15'b00_00_00_01_0_0_0_1_0_0_0;
    localparam logic [14:0] E_MWR_W  = 15'b00_00_00_00_1_0_0_0_0_1_0;
    localparam logic [14:0] E_MWR_R  = 15'b00_00_00_00_1_0_0_0_1_1_0;
    localparam logic [14:0] E_EXR    = 15'b10_10_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] E_EXI    = 15'b10_10_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] E_JAL    = 15'b00_01_10_00_0_0_1_0_0_0_0;
    localparam logic [14:0] E_AWB    = 15'b00_00_00_00_0_0_0_1_0_0_0;
    localparam logic [14:0] E_BEQ_T  = 15'b01_10_00_00_0_0_1_0_0_0_0;
    localparam logic [14:0] E_BEQ_N  = 15'b01_10_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] E_TRAP   = 15'b00_00_00_00_0_0_0_0_0_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = C_R;
    logic       zero = 1'b0;
    logic       memReady = 1'b1;
    logic [1:0] aluOp, aluSrcA, aluSrcB, resultSrc;
    logic       adrSrc, irWrite, pcWrite, regWrite, memWrite, memReq, illegal;
    logic [14:0] obs;

    int errors = 0;
    int checks = 0;

    main_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .memReady  (memReady),
        .aluOp     (aluOp),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .resultSrc (resultSrc),
        .adrSrc    (adrSrc),
        .irWrite   (irWrite),
        .pcWrite   (pcWrite),
        .regWrite  (regWrite),
        .memWrite  (memWrite),
        .memReq    (memReq),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, pcWrite,
                  regWrite, memWrite, memReq, illegal};

    task automatic check(input string tag, input logic [14:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    // One cycle: apply inputs, check mid-cycle, then cross the next rising edge.
    task automatic step(input string tag, input logic [6:0] o, input logic mr,
                        input logic z, input logic [14:0] expected);
        op = o;
        memReady = mr;
        zero = z;
        #1;
        check(tag, expected);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst.outputs", E_RST);
        @(posedge clk);
        #1;
        check("rst.hold", E_RST);
        rst_n = 1'b1;

        // R-type; memReady low in DECODE must be ignored
        step("add.fetch",  C_R, 1'b1, 1'b0, E_F_RDY);
        step("add.decode", C_R, 1'b0, 1'b0, E_DEC);
        step("add.execr",  C_R, 1'b1, 1'b0, E_EXR);
        step("add.aluwb",  C_R, 1'b1, 1'b0, E_AWB);

        step("addi.fetch",  C_I, 1'b1, 1'b0, E_F_RDY);
        step("addi.decode", C_I, 1'b1, 1'b0, E_DEC);
        step("addi.execi",  C_I, 1'b1, 1'b0, E_EXI);
        step("addi.aluwb",  C_I, 1'b1, 1'b0, E_AWB);

        // lw with two wait cycles in MEMREAD: 7 cycles total
        step("lw.fetch",   C_LW, 1'b1, 1'b0, E_F_RDY);
        step("lw.decode",  C_LW, 1'b1, 1'b0, E_DEC);
        step("lw.memadr",  C_LW, 1'b1, 1'b0, E_MADR);
        step("lw.memrd0",  C_LW, 1'b0, 1'b0, E_MRD);
        step("lw.memrd1",  C_LW, 1'b0, 1'b0, E_MRD);
        step("lw.memrd2",  C_LW, 1'b1, 1'b0, E_MRD);
        step("lw.memwb",   C_LW, 1'b1, 1'b0, E_MWB);

        step("beqT.fetch",  C_BEQ, 1'b1, 1'b1, E_F_RDY);
        step("beqT.decode", C_BEQ, 1'b1, 1'b1, E_DEC);
        step("beqT.beq",    C_BEQ, 1'b1, 1'b1, E_BEQ_T);
        step("beqN.fetch",  C_BEQ, 1'b1, 1'b0, E_F_RDY);
        step("beqN.decode", C_BEQ, 1'b1, 1'b0, E_DEC);
        step("beqN.beq",    C_BEQ, 1'b1, 1'b0, E_BEQ_N);

        step("jal.fetch",  C_JAL, 1'b1, 1'b0, E_F_RDY);
        step("jal.decode", C_JAL, 1'b1, 1'b0, E_DEC);
        step("jal.jal",    C_JAL, 1'b1, 1'b0, E_JAL);
        step("jal.aluwb",  C_JAL, 1'b1, 1'b0, E_AWB);

        // sw with memReady toggling in FETCH and MEMWRITE
        step("sw.fetchW",  C_SW, 1'b0, 1'b0, E_F_WAIT);
        step("sw.fetchR",  C_SW, 1'b1, 1'b0, E_F_RDY);
        step("sw.decode",  C_SW, 1'b1, 1'b0, E_DEC);
        step("sw.memadr",  C_SW, 1'b1, 1'b0, E_MADR);
        step("sw.memwrW",  C_SW, 1'b0, 1'b0, E_MWR_W);
        step("sw.memwrR",  C_SW, 1'b1, 1'b0, E_MWR_R);

        // unsupported opcode
        step("ill.fetch",  C_BAD, 1'b1, 1'b0, E_F_RDY);
        step("ill.decode", C_BAD, 1'b1, 1'b0, E_DEC);
`ifdef MAIN_FSM_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            step($sformatf("ill.trap%0d", i), C_BAD, 1'b1, 1'b1, E_TRAP);
        end
`else
        step("ill.back_fetch", C_BAD, 1'b0, 1'b0, E_F_WAIT);
`endif
        rst_n = 1'b0;
        #1;
        check("ill.reset", E_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset in the middle of MEMWRITE with memReady high
        step("swrst.fetch",  C_SW, 1'b1, 1'b0, E_F_RDY);
        step("swrst.decode", C_SW, 1'b1, 1'b0, E_DEC);
        step("swrst.memadr", C_SW, 1'b1, 1'b0, E_MADR);
        memReady = 1'b1;
        #1;
        check("swrst.memwrite", E_MWR_R);
        rst_n = 1'b0;
        #1;
        check("swrst.abort", E_RST);
        @(posedge clk);
        #1;
        check("swrst.hold", E_RST);
        memReady = 1'b0;
        rst_n = 1'b1;
        #1;
        check("swrst.release", E_F_WAIT);
        @(posedge clk);
        #1;
        step("swrst.wait",  C_SW, 1'b0, 1'b0, E_F_WAIT);
        step("swrst.ready", C_SW, 1'b1, 1'b0, E_F_RDY);
        step("swrst.dec",   C_SW, 1'b1, 1'b0, E_DEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
